// File: rtl/sec_clock_gen.sv
// rtl/sec_clock_gen.sv - 1 Hz seconds timebase with 0..59 seconds count and minute tick/clock.
// Optional crystal trim input enabled by macro SEC_CLK_TRIM_EN.
module sec_clock_gen #(
  parameter int CLK_FREQ_HZ = 10000,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
`ifdef SEC_CLK_TRIM_EN
  input  logic signed [7:0] trim,
`endif
  output logic              sec_tick,
  output logic              sec_clk,
  output logic [5:0]        sec_count,
  output logic              min_tick,
  output logic              min_clk
);

  localparam logic [CNT_W-1:0] DIV = CNT_W'(CLK_FREQ_HZ);

  logic [CNT_W-1:0] prescaler, pre_nxt;
  logic [CNT_W-1:0] period;
  logic [5:0]       cnt_nxt;
  logic             tick_nxt, mtick_nxt, sclk_nxt, mclk_nxt;
  logic             wrap;

  assign wrap = en && !clr && (prescaler == period - CNT_W'(1));

`ifdef SEC_CLK_TRIM_EN
  logic signed [CNT_W+1:0] trim_sum;
  logic [CNT_W-1:0]        trim_period;
  logic [CNT_W-1:0]        period_q;
  logic                    load_pend;

  assign trim_sum    = $signed({2'b00, DIV}) + (CNT_W+2)'(trim);
  assign trim_period = (trim_sum < 4) ? CNT_W'(4) : trim_sum[CNT_W-1:0];
  assign period      = period_q;

  // The first edge after reset cannot wrap (prescaler 0 < period-1), so the
  // trim captured there is in effect for the whole first second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q  <= DIV;
      load_pend <= 1'b1;
    end else begin
      if (clr || load_pend || wrap) period_q <= trim_period;
      load_pend <= 1'b0;
    end
  end
`else
  assign period = DIV;
`endif

  always_comb begin
    pre_nxt   = prescaler;
    cnt_nxt   = sec_count;
    tick_nxt  = 1'b0;
    mtick_nxt = 1'b0;
    sclk_nxt  = sec_clk;
    mclk_nxt  = min_clk;
    if (clr) begin
      pre_nxt  = '0;
      cnt_nxt  = '0;
      sclk_nxt = 1'b0;
      mclk_nxt = 1'b0;
    end else if (en) begin
      if (wrap) begin
        pre_nxt  = '0;
        tick_nxt = 1'b1;
        if (sec_count == 6'd59) begin
          cnt_nxt   = '0;
          mtick_nxt = 1'b1;
        end else begin
          cnt_nxt = sec_count + 6'd1;
        end
      end else begin
        pre_nxt = prescaler + CNT_W'(1);
      end
      sclk_nxt = (pre_nxt >= (period >> 1));
      mclk_nxt = (cnt_nxt >= 6'd30);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      sec_count <= '0;
      sec_tick  <= 1'b0;
      sec_clk   <= 1'b0;
      min_tick  <= 1'b0;
      min_clk   <= 1'b0;
    end else begin
      prescaler <= pre_nxt;
      sec_count <= cnt_nxt;
      sec_tick  <= tick_nxt;
      sec_clk   <= sclk_nxt;
      min_tick  <= mtick_nxt;
      min_clk   <= mclk_nxt;
    end
  end

endmodule

// File: tb/tb_sec_clock_gen.sv
// tb/tb_sec_clock_gen.sv - directed self-checking bench for sec_clock_gen at CLK_FREQ_HZ=10.
module tb_sec_clock_gen;

  logic       clk = 1'b0;
  logic       rst_n, en, clr;
  logic       sec_tick, sec_clk, min_tick, min_clk;
  logic [5:0] sec_count;
`ifdef SEC_CLK_TRIM_EN
  logic signed [7:0] trim;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sec_clock_gen #(.CLK_FREQ_HZ(10), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
`ifdef SEC_CLK_TRIM_EN
    .trim      (trim),
`endif
    .sec_tick  (sec_tick),
    .sec_clk   (sec_clk),
    .sec_count (sec_count),
    .min_tick  (min_tick),
    .min_clk   (min_clk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sec_tick, sec_clk, min_tick, min_clk, sec_count}
  function automatic logic [9:0] outs();
    return {sec_tick, sec_clk, min_tick, min_clk, sec_count};
  endfunction

  // Edges until the next sec_tick is seen; n = 999 on timeout.
  task automatic edges_to_tick(output int n, output int hi);
    n  = 999;
    hi = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      hi += int'(sec_clk);
      if (sec_tick) begin
        n = i;
        break;
      end
    end
  endtask

  int pre_m, cnt_m, sticks, mticks, n, hi;
  logic exp_t, exp_mt;

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
`ifdef SEC_CLK_TRIM_EN
    trim = 8'sd0;
`endif
    #23;
    check("rst_outs", 32'(outs()), 32'd0);
    step();
    rst_n = 1'b1; en = 1'b1;

    // First second: sec_clk rises after 5 edges, tick after 10th edge.
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("t1_sclk_e%0d", e), 32'(sec_clk), 32'(e >= 5 && e <= 9));
      check($sformatf("t1_tick_e%0d", e), 32'(sec_tick), 32'(e == 10));
    end
    check("t1_count", 32'(sec_count), 32'd1);

    // Remaining 59 seconds of the minute.
    pre_m = 0; cnt_m = 1; sticks = 0; mticks = 0;
    for (int e = 1; e <= 590; e++) begin
      step();
      exp_t = 1'b0; exp_mt = 1'b0;
      if (pre_m == 9) begin
        pre_m = 0; exp_t = 1'b1;
        if (cnt_m == 59) begin cnt_m = 0; exp_mt = 1'b1; end
        else cnt_m++;
      end else pre_m++;
      sticks += int'(sec_tick);
      mticks += int'(min_tick);
      check($sformatf("t2_e%0d", e), 32'(outs()),
            32'({exp_t, pre_m >= 5, exp_mt, cnt_m >= 30, 6'(cnt_m)}));
    end
    check("t2_sticks", 32'(sticks), 32'd59);
    check("t2_mticks", 32'(mticks), 32'd1);

    // Hold en low for 7 cycles at prescaler=3.
    repeat (3) step();
    en = 1'b0;
    repeat (7) begin
      step();
      check("t3_hold_tick", 32'(sec_tick), 32'd0);
    end
    check("t3_hold_count", 32'(sec_count), 32'd0);
    en = 1'b1;
    edges_to_tick(n, hi);
    check("t3_interval", 32'(n + 10), 32'd17);
    check("t3_count", 32'(sec_count), 32'd1);

    // Clear at prescaler=6, sec_count=42.
    repeat (416) step();
    check("t4_pre_count", 32'(sec_count), 32'd42);
    check("t4_pre_mclk", 32'(min_clk), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr_outs", 32'(outs()), 32'd0);
    edges_to_tick(n, hi);
    check("t4_interval", 32'(n), 32'd10);
    check("t4_count", 32'(sec_count), 32'd1);

    // Asynchronous reset between edges while sec_clk is high.
    repeat (5) step();
    check("t5_sclk_high", 32'(sec_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_outs", 32'(outs()), 32'd0);

`ifdef SEC_CLK_TRIM_EN
    trim = -8'sd2;
    step();
    rst_n = 1'b1;
    edges_to_tick(n, hi);
    check("t6_first_period", 32'(n), 32'd8);
    edges_to_tick(n, hi);
    check("t6_period", 32'(n), 32'd8);
    check("t6_sclk_high", 32'(hi), 32'd4);
    trim = -8'sd100;
    edges_to_tick(n, hi);
    check("t6_prev_period", 32'(n), 32'd8);
    edges_to_tick(n, hi);
    check("t6_clamp_period", 32'(n), 32'd4);
    check("t6_clamp_high", 32'(hi), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
